// File: rtl/lfa_adc_reader.sv
// rtl/lfa_adc_reader.sv - ADC128S022 round-robin reader for the three LFA sensors
module lfa_adc_reader #(
  parameter logic [2:0] LEFT_CH   = 3'd3,
  parameter logic [2:0] MIDDLE_CH = 3'd4,
  parameter logic [2:0] RIGHT_CH  = 3'd5
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] middle,
  output logic [11:0] right,
  output logic        data_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  p;
  logic [3:0]  bidx;
  logic [1:0]  slot, prev_slot;
  logic [2:0]  addr;
  logic        prime;
  logic [11:0] shreg;
  logic [11:0] sample_word;
  logic        frame_end;

  assign bidx        = p[4:1];
  assign frame_end   = (state == SHIFT) && (p == 5'd31);
  // The last bit arrives on p = 31, so the stored word includes it directly.
  assign sample_word = {shreg[10:0], adc_dout};

  always_comb begin
    case (slot)
      2'd0:    addr = LEFT_CH;
      2'd1:    addr = MIDDLE_CH;
      default: addr = RIGHT_CH;
    endcase
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adc_cs_n  = 1'b1;
    adc_sclk  = 1'b1;
    adc_din   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en) state_nxt = START;
      end
      START: begin
        adc_cs_n  = 1'b0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = p[0];
        case (bidx)
          4'd2:    adc_din = addr[2];
          4'd3:    adc_din = addr[1];
          4'd4:    adc_din = addr[0];
          default: adc_din = 1'b0;
        endcase
        if (p == 5'd31) state_nxt = GAP;
      end
      GAP: begin
        if (p == 5'd1) state_nxt = en ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      p          <= 5'd0;
      slot       <= 2'd0;
      prev_slot  <= 2'd0;
      prime      <= 1'b0;
      shreg      <= 12'd0;
      left       <= 12'd0;
      middle     <= 12'd0;
      right      <= 12'd0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          p <= 5'd0;
          if (en) begin
            slot  <= 2'd0;
            prime <= 1'b0;
          end
        end
        START: p <= 5'd0;
        SHIFT: begin
          p <= p + 5'd1;
          if (p[0] && (bidx >= 4'd4)) shreg <= sample_word;
          if (frame_end) begin
            prime     <= 1'b1;
            prev_slot <= slot;
            slot      <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            // The ADC answers one frame late, so the word belongs to prev_slot.
            if (prime) begin
              case (prev_slot)
                2'd0: left <= sample_word;
                2'd1: middle <= sample_word;
                default: begin
                  right      <= sample_word;
                  data_valid <= 1'b1;
                end
              endcase
            end
          end
        end
        GAP: p <= (p == 5'd1) ? 5'd0 : p + 5'd1;
        default: p <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_lfa_adc_reader.sv
// tb/tb_lfa_adc_reader.sv - self-checking bench with ADC128S022 model for lfa_adc_reader
module tb_lfa_adc_reader;

  logic        clk_3125KHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic [11:0] left, middle, right;
  logic        data_valid, busy;

  int checks = 0;
  int errors = 0;

  always #160 clk_3125KHz = ~clk_3125KHz;

  lfa_adc_reader dut (
    .clk_3125KHz(clk_3125KHz),
    .rst_n      (rst_n),
    .en         (en),
    .adc_dout   (adc_dout),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_din    (adc_din),
    .left       (left),
    .middle     (middle),
    .right      (right),
    .data_valid (data_valid),
    .busy       (busy)
  );

  // ADC model plus frame-level reference model of the reader outputs.
  logic [11:0] mem [0:7];
  bit          rand_data = 0;
  logic [2:0]  adc_addr = 3'd0;
  logic [2:0]  rx_addr = 3'd0;
  logic [11:0] tx_val = 12'd0;
  logic [11:0] exp_out [0:2];
  logic        exp_dv;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [2:0]  last_addr = 3'd0;
  int falls = 0, toggles = 0, low_len = 0, hi_len = 100;
  int frame_idx = -1, frame_done = 0, cyc = 0, fall_cyc = 0;
  int last_low_len = 0, last_toggles = 0, last_idx = 0, last_period = 0;
  int dv_bad = 0, out_bad = 0, dv_count = 0, dv_period = 0, last_dv_cyc = 0;

  function automatic logic [2:0] ch_of(int i);
    case (i % 3)
      0:       return 3'd3;
      1:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  always @(negedge clk_3125KHz) begin
    cyc++;
    exp_dv = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) exp_out[k] = 12'd0;
      hi_len    = 100;
      low_len   = 0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      adc_dout  = 1'b0;
    end else begin
      if (!adc_cs_n && prev_cs) begin
        frame_idx   = (hi_len > 2) ? 0 : frame_idx + 1;
        last_period = cyc - fall_cyc;
        fall_cyc    = cyc;
        if (rand_data) mem[adc_addr] = 12'($urandom_range(0, 4095));
        tx_val  = mem[adc_addr];
        falls   = 0;
        toggles = 0;
        low_len = 0;
        rx_addr = 3'd0;
      end
      if (!adc_cs_n) begin
        low_len++;
        hi_len = 0;
        if (adc_sclk != prev_sclk) toggles++;
        if (!adc_sclk && prev_sclk) begin
          adc_dout = (falls >= 4) ? tx_val[15 - falls] : 1'b0;
          falls++;
        end
        if (adc_sclk && !prev_sclk && falls >= 3 && falls <= 5) rx_addr[5 - falls] = adc_din;
      end else begin
        if (!prev_cs) begin
          last_addr    = rx_addr;
          last_low_len = low_len;
          last_toggles = toggles;
          last_idx     = frame_idx;
          if (frame_idx >= 1) begin
            exp_out[(frame_idx - 1) % 3] = tx_val;
            exp_dv = ((frame_idx - 1) % 3 == 2);
          end
          adc_addr = rx_addr;
          frame_done++;
        end
        hi_len++;
      end
      prev_cs   = adc_cs_n;
      prev_sclk = adc_sclk;
      if (data_valid !== exp_dv) dv_bad++;
      if (data_valid) begin
        dv_count++;
        dv_period   = cyc - last_dv_cyc;
        last_dv_cyc = cyc;
      end
      if ({left, middle, right} !== {exp_out[0], exp_out[1], exp_out[2]}) out_bad++;
    end
  end

  task automatic tick();
    @(negedge clk_3125KHz);
    #2;
  endtask

  task automatic wait_frame();
    int start = frame_done;
    int n = 0;
    while (frame_done == start && n < 200) begin
      tick();
      n++;
    end
    if (frame_done == start) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no frame end within %0d cycles", n);
    end
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (adc_cs_n !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (adc_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL cs_low_timeout: adc_cs_n=%b required 0", adc_cs_n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b want 1", adc_sclk); end
    checks++; if (adc_din !== 1'b0) begin errors++; $display("FAIL rst_din: got %b want 0", adc_din); end
    checks++; if ({left, middle, right} !== 36'd0) begin errors++; $display("FAIL rst_outputs: got %h want 0", {left, middle, right}); end
    checks++; if ({data_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_dv_busy: got %b want 00", {data_valid, busy}); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if ({busy, adc_cs_n} !== 2'b01) begin errors++; $display("FAIL idle_hold: busy,cs_n got %b want 01", {busy, adc_cs_n}); end
  endtask

  task automatic test_basic_frames();
    int dv0 = dv_count, ob = out_bad, db = dv_bad;
    mem[0] = 12'hBAD; mem[3] = 12'h0A5; mem[4] = 12'h7FF; mem[5] = 12'hF00;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_frame();
      checks++;
      if (last_idx != i || last_addr !== ch_of(i)) begin
        errors++; $display("FAIL frame_addr: frame %0d got idx %0d addr %0d want addr %0d", i, last_idx, last_addr, ch_of(i));
      end
      checks++; if (last_low_len != 33) begin errors++; $display("FAIL cs_low_len: got %0d want 33", last_low_len); end
      checks++; if (last_toggles != 32) begin errors++; $display("FAIL sclk_toggles: got %0d want 32", last_toggles); end
      if (i > 0) begin
        checks++; if (last_period != 35) begin errors++; $display("FAIL frame_period: got %0d want 35", last_period); end
      end
      case (i)
        0: begin checks++; if (left !== 12'h000) begin errors++; $display("FAIL prime_discard: left got %h want 000", left); end end
        1: begin checks++; if (left !== 12'h0A5) begin errors++; $display("FAIL left_value: got %h want 0a5", left); end end
        2: begin checks++; if (middle !== 12'h7FF) begin errors++; $display("FAIL middle_value: got %h want 7ff", middle); end end
        default: begin
          checks++; if (right !== 12'hF00) begin errors++; $display("FAIL right_value: got %h want f00", right); end
          checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL dv_with_right: got %b want 1", data_valid); end
          tick();
          checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL dv_one_cycle: got %b want 0", data_valid); end
        end
      endcase
    end
    checks++; if (dv_count - dv0 != 1) begin errors++; $display("FAIL dv_count_basic: got %0d want 1", dv_count - dv0); end
    checks++; if (out_bad != ob) begin errors++; $display("FAIL outputs_basic: %0d cycles differ, want 0", out_bad - ob); end
    checks++; if (dv_bad != db) begin errors++; $display("FAIL dv_basic: %0d cycles differ, want 0", dv_bad - db); end
  endtask

  task automatic test_en_drop();
    int n = 0;
    en = 1'b0;
    while (busy && n < 100) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout: busy got %b want 0", busy); end
    mem[3] = 12'h123; mem[4] = 12'h456;
    en = 1'b1;
    wait_frame();
    wait_cs_low();
    repeat (11) tick();
    en = 1'b0;
    wait_frame();
    checks++; if (last_addr !== 3'd4 || last_idx != 1) begin errors++; $display("FAIL drop_frame_addr: got addr %0d idx %0d want 4 1", last_addr, last_idx); end
    checks++; if (left !== 12'h123) begin errors++; $display("FAIL drop_left: got %h want 123", left); end
    repeat (3) tick();
    checks++; if ({busy, adc_cs_n} !== 2'b01) begin errors++; $display("FAIL drop_idle: busy,cs_n got %b want 01", {busy, adc_cs_n}); end
    en = 1'b1;
    wait_frame();
    checks++; if (last_addr !== 3'd3 || last_idx != 0) begin errors++; $display("FAIL reenable_addr: got addr %0d idx %0d want 3 0", last_addr, last_idx); end
    checks++; if (left !== 12'h123) begin errors++; $display("FAIL reenable_discard: left got %h want 123", left); end
  endtask

  task automatic test_reset_mid_frame();
    wait_cs_low();
    repeat (21) tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({adc_cs_n, adc_sclk, adc_din} !== 3'b110) begin errors++; $display("FAIL async_rst_pins: got %b want 110", {adc_cs_n, adc_sclk, adc_din}); end
    checks++; if ({left, middle, right} !== 36'd0) begin errors++; $display("FAIL async_rst_outputs: got %h want 0", {left, middle, right}); end
    checks++; if ({busy, data_valid} !== 2'b00) begin errors++; $display("FAIL async_rst_busy: got %b want 00", {busy, data_valid}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({adc_cs_n, busy} !== 2'b01) begin errors++; $display("FAIL first_edge_start: cs_n,busy got %b want 01", {adc_cs_n, busy}); end
    wait_frame();
    checks++; if (last_addr !== 3'd3 || last_idx != 0 || left !== 12'd0) begin
      errors++; $display("FAIL rst_reprime: addr %0d idx %0d left %h want 3 0 000", last_addr, last_idx, left);
    end
    wait_frame();
    checks++; if (left !== 12'h123) begin errors++; $display("FAIL rst_first_left: got %h want 123", left); end
  endtask

  task automatic test_continuous();
    int dv0 = dv_count, ob = out_bad, db = dv_bad, exp_n = 0, addr_err = 0;
    rand_data = 1;
    for (int f = 0; f < 300; f++) begin
      wait_frame();
      if (last_idx >= 1 && (last_idx - 1) % 3 == 2) exp_n++;
      checks++;
      if (last_addr !== ch_of(last_idx) || last_low_len != 33) begin
        errors++; addr_err++;
        if (addr_err < 5) $display("FAIL cont_frame: idx %0d addr %0d len %0d want addr %0d len 33", last_idx, last_addr, last_low_len, ch_of(last_idx));
      end
    end
    checks++; if (dv_count - dv0 != exp_n) begin errors++; $display("FAIL cont_dv_count: got %0d want %0d", dv_count - dv0, exp_n); end
    checks++; if (dv_period != 105) begin errors++; $display("FAIL cont_dv_period: got %0d want 105", dv_period); end
    checks++; if (out_bad != ob) begin errors++; $display("FAIL cont_outputs: %0d cycles differ, want 0", out_bad - ob); end
    checks++; if (dv_bad != db) begin errors++; $display("FAIL cont_dv: %0d cycles differ, want 0", dv_bad - db); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = 12'd0;
    for (int k = 0; k < 3; k++) exp_out[k] = 12'd0;
    test_reset();
    test_basic_frames();
    test_en_drop();
    test_reset_mid_frame();
    test_continuous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(320 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfa_adc_reader.md
LFA_ADC_READER -- requirements
Module: lfa_adc_reader

Interface
REQ-001 The block SHALL have parameter LEFT_CH, default 3'd3, giving the ADC channel address of the left LFA sensor.
REQ-002 The block SHALL have parameter MIDDLE_CH, default 3'd4, giving the ADC channel address of the middle LFA sensor.
REQ-003 The block SHALL have parameter RIGHT_CH, default 3'd5, giving the ADC channel address of the right LFA sensor.
REQ-004 The block SHALL have port clk_3125KHz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: enables continuous conversion.
REQ-007 The block SHALL have port adc_dout, input, 1 bit: serial data from the ADC128S022.
REQ-008 The block SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-009 The block SHALL have port adc_sclk, output, 1 bit: ADC serial clock.
REQ-010 The block SHALL have port adc_din, output, 1 bit: ADC control and address bits.
REQ-011 The block SHALL have ports left, middle and right, each output, 12 bits: the latest conversion for each sensor.
REQ-012 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse indicating that a full left/middle/right set has been refreshed.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-014 The FSM SHALL have states IDLE, START, SHIFT and GAP.
- IDLE -> START when en = 1.
- START lasts 1 cycle, with adc_cs_n = 0 and adc_sclk = 1.
- SHIFT lasts exactly 32 cycles, phase counter p = 0..31.
- GAP lasts 2 cycles, with adc_cs_n = 1.
- GAP -> START if en = 1, otherwise GAP -> IDLE.
REQ-015 In SHIFT, adc_sclk SHALL be 0 for even p and 1 for odd p, giving SCLK = clk/2 = 1.5625 MHz and 16 SCLK periods per frame; adc_sclk SHALL be 1 outside SHIFT.
REQ-016 For bit index b = p/2, adc_din SHALL hold ADDR[2] at b = 2, ADDR[1] at b = 3 and ADDR[0] at b = 4, and 0 otherwise; ADDR is the current frame's address, and adc_din changes only on even p.
REQ-017 adc_dout SHALL be sampled on the cycle where p is odd (SCLK rising edge) for b = 4..15, shifted MSB first into a 12-bit register; bits b = 0..3 are ignored.
REQ-018 Addresses SHALL cycle LEFT_CH -> MIDDLE_CH -> RIGHT_CH -> LEFT_CH ..., advancing once per frame.
REQ-019 Data received in frame k SHALL belong to the address sent in frame k-1 (ADC pipeline latency of one frame).
REQ-020 A prime flag SHALL be cleared on entry to START from IDLE; the data of that first frame SHALL be discarded, and the flag SHALL be set at the end of the frame.
REQ-021 On the cycle after p = 31, the shift register SHALL be written to the output named by the previous frame's address, if prime = 1.
REQ-022 data_valid SHALL pulse for 1 cycle on the same cycle that right is written.
REQ-023 Outputs left, middle and right SHALL hold their value between updates and never show partial data.
REQ-024 Deassertion of en mid-frame SHALL NOT abort the frame; the frame SHALL complete, the data SHALL be stored, and then the FSM SHALL go GAP -> IDLE.
REQ-025 The address sequence SHALL restart at LEFT_CH after each IDLE.
REQ-026 busy SHALL be 1 in START, SHIFT and GAP, and 0 in IDLE.

Reset
REQ-027 While rst_n = 0, the block SHALL be in IDLE with adc_cs_n = 1, adc_sclk = 1, adc_din = 0, left = middle = right = 0, data_valid = 0, busy = 0, prime = 0, p = 0 and the address pointer at LEFT_CH.
REQ-028 Assertion of rst_n mid-frame SHALL immediately force the reset values (adc_cs_n = 1 within the same cycle, asynchronously); no output register SHALL be updated by the aborted frame.
REQ-029 The first edge of clk_3125KHz after rst_n rises SHALL be able to leave IDLE if en = 1.

Verification
REQ-030 en = 1 with an ADC model returning ch3 = 0x0A5, ch4 = 0x7FF, ch5 = 0xF00 -> the first frame is discarded; left = 0x0A5, then middle = 0x7FF, then right = 0xF00; data_valid pulses once; 35 cycles per frame.
REQ-031 Check adc_din pattern per frame: frame 0 sends 011 at b = 2..4, frame 1 sends 100, frame 2 sends 101, then 011 repeats; adc_sclk toggles 32 times per frame; adc_cs_n is low for exactly 33 cycles.
REQ-032 en dropped at p = 10 of the middle-address frame -> the frame completes, left is updated with the data from the previous frame, the FSM goes IDLE, busy = 0; on re-enable the next addresses are LEFT_CH and the first frame is discarded.
REQ-033 rst_n pulsed low at p = 20 of a frame -> adc_cs_n = 1 immediately; all outputs are 0; after release with en = 1 the sequence restarts at LEFT_CH with priming.
REQ-034 Continuous run of 300 frames with random ADC data -> every data_valid follows a right update; left, middle and right match the model; the data_valid period is 105 cycles.
